// File: rtl/memory_bridge.sv
// Single-outstanding bridge from the core memory handshake to a req/ack bus with wait states.
// Optional bus timeout is built when MEMORY_BRIDGE_TIMEOUT_EN is defined.
module memory_bridge #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int COUNTER_WIDTH  = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_enable,
  input  logic        memory_command,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_data,
  input  logic [3:0]  memory_byte_enable,
  output logic        memory_ready,
  output logic        memory_valid,
  output logic [31:0] memory_read_data,
  output logic        memory_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  debug_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   accept;
  logic   ack_hit;
  logic   timeout_hit;

  // Handshake outputs are pure state decodes, so they change with the async reset
  assign memory_ready = (state_q == IDLE);
  assign memory_valid = (state_q == RESPOND);
  assign bus_req      = (state_q == REQUEST);
  assign debug_state  = state_q;

  assign accept  = (state_q == IDLE) && memory_enable;
  assign ack_hit = (state_q == REQUEST) && bus_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (memory_enable) state_d = REQUEST;
      REQUEST: if (bus_ack || timeout_hit) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_we           <= 1'b0;
      bus_addr         <= '0;
      bus_wdata        <= '0;
      bus_be           <= '0;
      memory_read_data <= '0;
    end else begin
      if (accept) begin
        bus_we    <= memory_command;
        bus_addr  <= memory_address & 32'hFFFF_FFFC;
        bus_wdata <= memory_write_data;
        bus_be    <= memory_command ? memory_byte_enable : 4'b1111;
      end
      // Write completions leave the last read value in place
      if (ack_hit && !bus_we) begin
        memory_read_data <= bus_rdata;
      end else if (timeout_hit) begin
        memory_read_data <= '0;
      end
    end
  end

`ifdef MEMORY_BRIDGE_TIMEOUT_EN
  logic [COUNTER_WIDTH-1:0] timeout_cnt;

  // An ack on the expiry cycle takes priority over the abort
  assign timeout_hit = (state_q == REQUEST) && !bus_ack &&
                       (timeout_cnt == COUNTER_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_cnt  <= '0;
      memory_error <= 1'b0;
    end else begin
      if (accept) begin
        timeout_cnt <= '0;
      end else if ((state_q == REQUEST) && !bus_ack) begin
        timeout_cnt <= timeout_cnt + COUNTER_WIDTH'(1);
      end
      memory_error <= timeout_hit;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign memory_error = 1'b0;
`endif

endmodule

// File: tb/tb_memory_bridge.sv
// Self-checking bench for memory_bridge: vector table, hand-written corner sequences and
// randomized accesses checked against a transaction-level model.
module tb_memory_bridge;

`ifdef MEMORY_BRIDGE_TIMEOUT_EN
  localparam int TO_CYC = 4;
  localparam int CW     = 3;
`else
  localparam int TO_CYC = 256;
  localparam int CW     = 9;
`endif

  logic        clk;
  logic        reset;
  logic        memory_enable;
  logic        memory_command;
  logic [31:0] memory_address;
  logic [31:0] memory_write_data;
  logic [3:0]  memory_byte_enable;
  logic        memory_ready;
  logic        memory_valid;
  logic [31:0] memory_read_data;
  logic        memory_error;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [1:0]  debug_state;

  memory_bridge #(.TIMEOUT_CYCLES(TO_CYC), .COUNTER_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .memory_enable(memory_enable), .memory_command(memory_command),
    .memory_address(memory_address), .memory_write_data(memory_write_data),
    .memory_byte_enable(memory_byte_enable), .memory_ready(memory_ready),
    .memory_valid(memory_valid), .memory_read_data(memory_read_data),
    .memory_error(memory_error), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .debug_state(debug_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Event counters sampled on the falling edge
  int   n_valid   = 0;
  int   n_req     = 0;
  int   n_overlap = 0;
  logic req_prev  = 1'b0;
  always @(negedge clk) begin
    if (memory_valid) n_valid <= n_valid + 1;
    if (bus_req && !req_prev) n_req <= n_req + 1;
    if (memory_valid && memory_ready) n_overlap <= n_overlap + 1;
    req_prev <= bus_req;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One access with enable held through completion; ack on request cycle number waits (0-based)
  task automatic do_txn(input logic cmd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int waits, input logic [31:0] rdata,
                        output int lat, output logic [31:0] o_addr, output logic [31:0] o_wdata,
                        output logic [3:0] o_be, output logic o_we, output logic [31:0] o_rd,
                        output logic o_err, output int unstable);
    int rq;
    memory_enable      = 1'b1;
    memory_command     = cmd;
    memory_address     = addr;
    memory_write_data  = wdata;
    memory_byte_enable = be;
    @(posedge clk); #1;
    memory_address     = $urandom;
    memory_write_data  = $urandom;
    memory_byte_enable = 4'($urandom);
    o_addr = bus_addr; o_wdata = bus_wdata; o_be = bus_be; o_we = bus_we;
    check("req_after_accept", {31'd0, bus_req}, 32'd1);
    lat = 1; rq = 0; unstable = 0;
    while (!memory_valid && lat < 50) begin
      bus_ack   = (rq == waits);
      bus_rdata = bus_ack ? rdata : $urandom;
      if (bus_req !== 1'b1 || memory_ready !== 1'b0 || bus_addr !== o_addr ||
          bus_wdata !== o_wdata || bus_be !== o_be || bus_we !== o_we)
        unstable++;
      @(posedge clk); #1;
      rq++; lat++;
    end
    bus_ack = 1'b0;
    o_rd = memory_read_data; o_err = memory_error;
    check("ready_low_in_valid", {31'd0, memory_ready}, 32'd0);
    @(posedge clk); #1;
    check("single_valid_pulse", {31'd0, memory_valid}, 32'd0);
    check("ready_back", {31'd0, memory_ready}, 32'd1);
    check("no_reaccept", {31'd0, bus_req}, 32'd0);
    memory_enable = 1'b0;
  endtask

  typedef struct {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_rd;
    int          e_lat;
  } vec_t;

  vec_t vt[3];

  int          lat, unst, v0, r0;
  logic [31:0] o_addr, o_wdata, o_rd, last_rd;
  logic [3:0]  o_be;
  logic        o_we, o_err;

  initial begin
    vt[0] = '{1'b0, 32'h0000_1006, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 32'h0000_1004, 4'hF, 32'hDEAD_BEEF, 2};
    vt[1] = '{1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 3, 32'h1111_2222, 32'h0000_0020, 4'b0010, 32'hDEAD_BEEF, 5};
    vt[2] = '{1'b0, 32'hFFFF_FFFF, 32'h5555_5555, 4'h3, 1, 32'h1234_5678, 32'hFFFF_FFFC, 4'hF, 32'h1234_5678, 3};

    reset = 1'b0; memory_enable = 1'b0; memory_command = 1'b0; memory_address = '0;
    memory_write_data = '0; memory_byte_enable = '0; bus_ack = 1'b0; bus_rdata = '0;
    #3;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check("rst_valid", {31'd0, memory_valid}, 32'd0);
    check("rst_error", {31'd0, memory_error}, 32'd0);
    check("rst_rdata", memory_read_data, 32'd0);
    check("rst_ready", {31'd0, memory_ready}, 32'd1);
    check("rst_state", {30'd0, debug_state}, 32'd0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      do_txn(vt[i].cmd, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].waits, vt[i].rdata,
             lat, o_addr, o_wdata, o_be, o_we, o_rd, o_err, unst);
      check($sformatf("vec%0d_addr", i), o_addr, vt[i].e_addr);
      check($sformatf("vec%0d_be", i), {28'd0, o_be}, {28'd0, vt[i].e_be});
      check($sformatf("vec%0d_we", i), {31'd0, o_we}, {31'd0, vt[i].cmd});
      check($sformatf("vec%0d_wdata", i), o_wdata, vt[i].wdata);
      check($sformatf("vec%0d_rdata", i), o_rd, vt[i].e_rd);
      check($sformatf("vec%0d_latency", i), lat, vt[i].e_lat);
      check($sformatf("vec%0d_error", i), {31'd0, o_err}, 32'd0);
      check($sformatf("vec%0d_stable", i), unst, 32'd0);
    end

    // Spurious acks while idle
    v0 = n_valid; r0 = n_req;
    bus_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus_ack = 1'b0;
    check("spur_no_req", n_req - r0, 32'd0);
    check("spur_no_valid", n_valid - v0, 32'd0);
    check("spur_bus_req", {31'd0, bus_req}, 32'd0);

    // Back-to-back reads with enable and ack held high
    v0 = n_valid; r0 = n_req;
    memory_command = 1'b0; memory_address = 32'h0000_0100;
    bus_ack = 1'b1; bus_rdata = 32'h600D_CAFE;
    memory_enable = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    memory_enable = 1'b0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("b2b_req_count", n_req - r0, 32'd2);
    check("b2b_valid_count", n_valid - v0, 32'd2);
    check("b2b_rdata", memory_read_data, 32'h600D_CAFE);

    // Reset during REQUEST
    v0 = n_valid;
    memory_enable = 1'b1; memory_command = 1'b0;
    @(posedge clk); #1;
    memory_enable = 1'b0;
    check("midrst_req_before", {31'd0, bus_req}, 32'd1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("midrst_req_async", {31'd0, bus_req}, 32'd0);
    check("midrst_state_async", {30'd0, debug_state}, 32'd0);
    check("midrst_rdata", memory_read_data, 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_ready", {31'd0, memory_ready}, 32'd1);
    check("midrst_no_valid", n_valid - v0, 32'd0);
    last_rd = 32'd0;

    // Randomized accesses against a transaction-level model
    for (int t = 0; t < 40; t++) begin
      logic        cmd;
      logic [31:0] addr, wdata, rdata;
      logic [3:0]  be;
      int          waits;
      cmd = 1'($urandom); addr = $urandom; wdata = $urandom; rdata = $urandom;
      be = 4'($urandom); waits = int'($urandom_range(0, 3));
      do_txn(cmd, addr, wdata, be, waits, rdata, lat, o_addr, o_wdata, o_be, o_we, o_rd, o_err, unst);
      if (!cmd) last_rd = rdata;
      check("rnd_addr", o_addr, (addr >> 2) << 2);
      check("rnd_be", {28'd0, o_be}, cmd ? {28'd0, be} : 32'd15);
      check("rnd_we", {31'd0, o_we}, {31'd0, cmd});
      if (cmd) check("rnd_wdata", o_wdata, wdata);
      check("rnd_rdata", o_rd, last_rd);
      check("rnd_latency", lat, waits + 2);
      check("rnd_stable", unst, 32'd0);
    end

`ifdef MEMORY_BRIDGE_TIMEOUT_EN
    do_txn(1'b0, 32'h0000_0400, 32'h0, 4'h0, 1000, 32'hAAAA_5555,
           lat, o_addr, o_wdata, o_be, o_we, o_rd, o_err, unst);
    check("to_latency", lat, TO_CYC + 1);
    check("to_error", {31'd0, o_err}, 32'd1);
    check("to_rdata", o_rd, 32'd0);
    check("to_error_clears", {31'd0, memory_error}, 32'd0);
    do_txn(1'b0, 32'h0000_0404, 32'h0, 4'h0, TO_CYC - 1, 32'hAAAA_5555,
           lat, o_addr, o_wdata, o_be, o_we, o_rd, o_err, unst);
    check("to_ack_wins_latency", lat, TO_CYC + 1);
    check("to_ack_wins_error", {31'd0, o_err}, 32'd0);
    check("to_ack_wins_rdata", o_rd, 32'hAAAA_5555);
`endif

    check("valid_ready_overlap", n_overlap, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
